// File: rtl/seq_ctrl_pkg.sv
// Shared encodings for the instruction sequencer and the ALU: opcodes, function codes,
// FSM states, instruction field positions and the instruction decoder.
package seq_ctrl_pkg;

  localparam int OP_HI = 8;
  localparam int OP_LO = 6;
  localparam int F_HI  = 5;
  localparam int F_LO  = 3;
  localparam int R_HI  = 2;
  localparam int R_LO  = 0;

  typedef enum logic [2:0] {
    OP_NOP0  = 3'b000,
    OP_NOP1  = 3'b001,
    OP_ADD   = 3'b010,
    OP_MATCH = 3'b011,
    OP_LT    = 3'b100,
    OP_DIST  = 3'b101,
    OP_ATYPE = 3'b110,
    OP_BTYPE = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    FN_LSL  = 3'b000,
    FN_LSR  = 3'b001,
    FN_INCR = 3'b010,
    FN_AND1 = 3'b011,
    FN_EQZ  = 3'b100,
    FN_ZERO = 3'b101,
    FN_NOP  = 3'b110,
    FN_HALT = 3'b111
  } afunc_e;

  localparam logic [2:0] FN_BNO = 3'b000;
  localparam logic [2:0] FN_BOF = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_e;

  typedef struct packed {
    logic [2:0] raddr_a;
    logic [2:0] raddr_b;
    logic [2:0] waddr;
    logic [5:0] opcode;
    logic       we;
    logic       upd_flag;
    logic       branch;
  } dec_t;

  function automatic dec_t decode(input logic [8:0] instr);
    dec_t       d;
    op_e        op;
    afunc_e     fn;
    logic [2:0] rd;
    logic [2:0] rg;
    op = op_e'(instr[OP_HI:OP_LO]);
    fn = afunc_e'(instr[F_HI:F_LO]);
    rd = instr[F_HI:F_LO];
    rg = instr[R_HI:R_LO];
    d  = '0;
    case (op)
      OP_ADD, OP_MATCH, OP_LT, OP_DIST: begin
        d.raddr_a  = rd;
        d.raddr_b  = rg;
        d.waddr    = rd;
        d.opcode   = {op, 3'b000};
        d.we       = (op == OP_ADD) || (op == OP_DIST);
        d.upd_flag = (op != OP_DIST);
      end
      OP_ATYPE: begin
        d.raddr_b  = rg;
        d.waddr    = rg;
        d.opcode   = {op, rd};
        d.we       = fn inside {FN_LSL, FN_LSR, FN_INCR, FN_ZERO};
        d.upd_flag = fn inside {FN_LSL, FN_AND1, FN_EQZ};
      end
      OP_BTYPE: d.branch = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic is_halt(input logic [8:0] instr);
    return (instr[OP_HI:OP_LO] == OP_ATYPE) && (instr[F_HI:F_LO] == FN_HALT);
  endfunction

endpackage

// File: rtl/seq_ctrl_if.sv
// Sequencer-side bus: instruction memory, register-file ports and ALU opcode/flag.
interface seq_ctrl_if #(parameter int PC_W = 8);
  logic [PC_W-1:0] imem_addr;
  logic [8:0]      imem_data;
  logic [2:0]      rf_raddr_a;
  logic [2:0]      rf_raddr_b;
  logic            rf_we;
  logic [2:0]      rf_waddr;
  logic [5:0]      alu_opcode;
  logic            alu_overflow;

  modport master (
    output imem_addr, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, alu_opcode,
    input  imem_data, alu_overflow
  );

  modport slave (
    input  imem_addr, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, alu_opcode,
    output imem_data, alu_overflow
  );
endinterface

// File: rtl/seq_ctrl_branch_lut.sv
// Constant branch-offset table: 3-bit index from the B-type instruction to a signed 8-bit pc offset.
module branch_lut (
  input  logic [2:0]        idx,
  output logic signed [7:0] offset
);
  always_comb begin
    offset = 8'sd0;
    case (idx)
      3'd0: offset = 8'sd0;
      3'd1: offset = -8'sd1;
      3'd2: offset = -8'sd4;
      3'd3: offset = 8'sd1;
      3'd4: offset = 8'sd2;
      3'd5: offset = 8'sd3;
      3'd6: offset = -8'sd8;
      3'd7: offset = 8'sh80;
      default: offset = 8'sd0;
    endcase
  end
endmodule

// File: rtl/seq_ctrl.sv
// Instruction sequencer: fetch/decode/exec/writeback FSM driving the registered ALU and register file.
// Optional retired-instruction counter enabled with `define SEQ_CTRL_INSTR_COUNT_EN.
module seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  seq_ctrl_if.master  bus,
  output logic        flag,
  output logic        done
`ifdef SEQ_CTRL_INSTR_COUNT_EN
  ,
  output logic [15:0] instr_count
`endif
);

  state_e            state, state_nx;
  logic [PC_W-1:0]   pc, pc_nx;
  logic [8:0]        ir;
  dec_t              dec;
  logic              halt_f;
  logic              taken;
  logic signed [7:0] br_off;
  logic [PC_W-1:0]   off_ext;

  branch_lut u_lut (.idx(ir[R_HI:R_LO]), .offset(br_off));

  assign dec     = decode(ir);
  assign halt_f  = is_halt(bus.imem_data);
  assign off_ext = PC_W'(br_off);
  assign taken   = ((ir[F_HI:F_LO] == FN_BNO) && !flag) ||
                   ((ir[F_HI:F_LO] == FN_BOF) && flag);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= START_PC;
      ir    <= '0;
      flag  <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (state == S_DECODE) ir <= bus.imem_data;
      if (state == S_WB && dec.upd_flag) flag <= bus.alu_overflow;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    case (state)
      S_IDLE:   if (start) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      // HALT is recognised straight off the memory bus so it never reaches the ALU
      S_DECODE: state_nx = halt_f ? S_HALTED : S_EXEC;
      S_EXEC: begin
        if (dec.branch) begin
          state_nx = S_FETCH;
          pc_nx    = taken ? pc + off_ext : pc + PC_W'(1);
        end else begin
          state_nx = S_WB;
        end
      end
      S_WB: begin
        state_nx = S_FETCH;
        pc_nx    = pc + PC_W'(1);
      end
      S_HALTED: ;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign bus.imem_addr  = pc;
  assign bus.rf_raddr_a = dec.raddr_a;
  assign bus.rf_raddr_b = dec.raddr_b;
  assign bus.rf_waddr   = dec.waddr;
  assign bus.rf_we      = (state == S_WB) && dec.we;
  assign bus.alu_opcode = (state == S_EXEC) ? dec.opcode : 6'd0;
  assign done           = (state == S_HALTED);

`ifdef SEQ_CTRL_INSTR_COUNT_EN
  logic retire;
  assign retire = (state == S_WB) || (state == S_EXEC && dec.branch) ||
                  (state == S_DECODE && halt_f);

  always_ff @(posedge clk) begin
    if (!rst_n)      instr_count <= 16'd0;
    else if (retire) instr_count <= instr_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl: memory/ALU/register-file environment plus an instruction-level model
// that predicts per-cycle bus activity and final architectural state.
module tb_seq_ctrl;
  localparam int PC_W = 8;
  localparam int MAXC = 700;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic flag, done;
`ifdef SEQ_CTRL_INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  seq_ctrl_if #(.PC_W(PC_W)) bus ();

  seq_ctrl #(.PC_W(PC_W), .START_PC(8'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus), .flag(flag), .done(done)
`ifdef SEQ_CTRL_INSTR_COUNT_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  // environment: imem, ALU and register file
  logic [8:0] imem [256];
  logic [7:0] rf [8];
  logic [7:0] init_rf [8];
  logic       load = 1'b0;
  logic [7:0] alu_res = 8'd0;
  logic       alu_ovf = 1'b0;

  // returns {overflow/flag, result}
  function automatic logic [8:0] alu_f(input logic [5:0] opc, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    case (opc[5:3])
      3'b010: return {1'b0, a} + {1'b0, b};
      3'b011: return {a == b, 8'h00};
      3'b100: return {a < b, 8'h00};
      3'b101: begin d = (a > b) ? a - b : b - a; return {d[0], d}; end
      3'b110: begin
        case (opc[2:0])
          3'd0: return {b[7], b << 1};
          3'd1: return {b[0], b >> 1};
          3'd2: return {b == 8'hff, b + 8'd1};
          3'd3: return {b[0], 7'd0, b[0]};
          3'd4: return {b == 8'd0, 8'h00};
          3'd5: return {1'b1, 8'h00};
          default: return {1'b1, b};
        endcase
      end
      default: return {1'b1, 8'h55};
    endcase
  endfunction

  assign bus.alu_overflow = alu_ovf;

  always @(posedge clk) begin
    bus.imem_data <= imem[bus.imem_addr];
    if (bus.alu_opcode != 6'd0)
      {alu_ovf, alu_res} <= alu_f(bus.alu_opcode, rf[bus.rf_raddr_a], rf[bus.rf_raddr_b]);
    if (load) rf <= init_rf;
    else if (bus.rf_we) rf[bus.rf_waddr] <= alu_res;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // instruction-level reference model
  logic [7:0] e_addr [MAXC];
  logic       e_we   [MAXC];
  logic [2:0] e_wa   [MAXC];
  logic [5:0] e_opc  [MAXC];
  int         e_len;
  logic [7:0] m_rf [8];
  logic       m_flag;
  logic [7:0] m_pc;
  int         m_cnt;
  bit         m_halt;
  int         lut [8] = '{0, -1, -4, 1, 2, 3, -8, -128};

  task automatic push(input logic [7:0] a, input logic [5:0] opc, input logic we, input logic [2:0] wa);
    e_addr[e_len] = a;
    e_opc[e_len]  = opc;
    e_we[e_len]   = we;
    e_wa[e_len]   = wa;
    e_len++;
  endtask

  task automatic model_run();
    int pc;
    pc = 0;
    m_rf = init_rf; m_flag = 1'b0; m_cnt = 0; m_halt = 1'b0; e_len = 0;
    while (!m_halt && e_len + 4 <= MAXC) begin
      logic [8:0] ins, r;
      logic [2:0] op, fn, rg, wa;
      logic [5:0] opc;
      logic [7:0] pc8;
      logic       wb, fo;
      ins = imem[pc]; op = ins[8:6]; fn = ins[5:3]; rg = ins[2:0];
      pc8 = pc[7:0];
      m_cnt++;
      if (op == 3'b110 && fn == 3'b111) begin
        push(pc8, 6'd0, 1'b0, 3'd0);
        push(pc8, 6'd0, 1'b0, 3'd0);
        m_halt = 1'b1;
      end else if (op == 3'b111) begin
        repeat (3) push(pc8, 6'd0, 1'b0, 3'd0);
        if ((fn == 3'd0 && !m_flag) || (fn == 3'd1 && m_flag)) pc = (pc + lut[rg]) & 255;
        else pc = (pc + 1) & 255;
      end else begin
        opc = 6'd0; wb = 1'b0; fo = 1'b0; wa = 3'd0; r = 9'd0;
        if (op >= 3'd2 && op <= 3'd5) begin
          opc = {op, 3'b000};
          r   = alu_f(opc, m_rf[fn], m_rf[rg]);
          wa  = fn;
          wb  = (op == 3'd2) || (op == 3'd5);
          fo  = (op != 3'd5);
        end else if (op == 3'd6) begin
          opc = {op, fn};
          r   = alu_f(opc, m_rf[0], m_rf[rg]);
          wa  = rg;
          wb  = (fn == 3'd0) || (fn == 3'd1) || (fn == 3'd2) || (fn == 3'd5);
          fo  = (fn == 3'd0) || (fn == 3'd3) || (fn == 3'd4);
        end
        push(pc8, 6'd0, 1'b0, 3'd0);
        push(pc8, 6'd0, 1'b0, 3'd0);
        push(pc8, opc, 1'b0, 3'd0);
        push(pc8, 6'd0, wb, wa);
        if (wb) m_rf[wa] = r[7:0];
        if (fo) m_flag = r[8];
        pc = (pc + 1) & 255;
      end
    end
    m_pc = pc[7:0];
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; load = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; load = 1'b0;
  endtask

  // reset, start, then compare every cycle against the model; final state if it halts
  task automatic run_prog(input string tag);
    model_run();
    apply_reset();
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < e_len; i++) begin
      chk({tag, ".addr"}, 32'(bus.imem_addr), 32'(e_addr[i]));
      chk({tag, ".opc"}, 32'(bus.alu_opcode), 32'(e_opc[i]));
      chk({tag, ".we"}, 32'(bus.rf_we), 32'(e_we[i]));
      if (e_we[i]) chk({tag, ".waddr"}, 32'(bus.rf_waddr), 32'(e_wa[i]));
      chk({tag, ".done"}, 32'(done), 32'd0);
      start = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    if (m_halt) begin
      chk({tag, ".halt_done"}, 32'(done), 32'd1);
      chk({tag, ".halt_pc"}, 32'(bus.imem_addr), 32'(m_pc));
      chk({tag, ".flag"}, 32'(flag), 32'(m_flag));
      for (int r = 0; r < 8; r++) chk($sformatf("%s.rf%0d", tag, r), 32'(rf[r]), 32'(m_rf[r]));
`ifdef SEQ_CTRL_INSTR_COUNT_EN
      chk({tag, ".icount"}, 32'(instr_count), 32'(m_cnt));
`endif
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk({tag, ".stay_done"}, 32'(done), 32'd1);
      chk({tag, ".stay_pc"}, 32'(bus.imem_addr), 32'(m_pc));
      chk({tag, ".stay_we"}, 32'(bus.rf_we), 32'd0);
    end
  endtask

  function automatic logic [8:0] enc(input logic [2:0] o, input logic [2:0] f, input logic [2:0] r);
    return {o, f, r};
  endfunction

  task automatic clear_prog();
    for (int a = 0; a < 256; a++) imem[a] = 9'd0;
    for (int r = 0; r < 8; r++) init_rf[r] = 8'd0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_prog();
    // reset state
    repeat (3) @(negedge clk);
    chk("rst.addr", 32'(bus.imem_addr), 32'd0);
    chk("rst.opc", 32'(bus.alu_opcode), 32'd0);
    chk("rst.we", 32'(bus.rf_we), 32'd0);
    chk("rst.waddr", 32'(bus.rf_waddr), 32'd0);
    chk("rst.ra", 32'(bus.rf_raddr_a), 32'd0);
    chk("rst.rb", 32'(bus.rf_raddr_b), 32'd0);
    chk("rst.flag", 32'(flag), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
`ifdef SEQ_CTRL_INSTR_COUNT_EN
    chk("rst.icount", 32'(instr_count), 32'd0);
`endif

    // ADD r1,r2 with carry out
    clear_prog();
    imem[0] = enc(3'b010, 3'd1, 3'd2);
    imem[1] = enc(3'b110, 3'd7, 3'd0);
    init_rf[1] = 8'd200; init_rf[2] = 8'd100;
    run_prog("add");

    // MATCH then BOF -1: self-sustaining loop back to 0
    clear_prog();
    imem[0] = enc(3'b011, 3'd0, 3'd0);
    imem[1] = enc(3'b111, 3'd1, 3'd1);
    run_prog("bof_loop");

    // MATCH then BNO: not taken, falls through to HALT at 2
    clear_prog();
    imem[0] = enc(3'b011, 3'd0, 3'd0);
    imem[1] = enc(3'b111, 3'd0, 3'd1);
    imem[2] = enc(3'b110, 3'd7, 3'd0);
    run_prog("bno");

    // EQZ on nonzero clears flag without writing; INCR r3 writes
    clear_prog();
    imem[0] = enc(3'b011, 3'd0, 3'd0);
    imem[1] = enc(3'b110, 3'd4, 3'd2);
    imem[2] = enc(3'b110, 3'd2, 3'd3);
    imem[3] = enc(3'b110, 3'd7, 3'd0);
    init_rf[2] = 8'd5; init_rf[3] = 8'd7;
    run_prog("eqz_incr");

    // assorted NOP encodings then HALT at 5
    clear_prog();
    imem[1] = enc(3'b001, 3'd5, 3'd5);
    imem[2] = enc(3'b110, 3'd6, 3'd1);
    imem[3] = enc(3'b111, 3'd2, 3'd3);
    imem[4] = enc(3'b111, 3'd7, 3'd0);
    imem[5] = enc(3'b110, 3'd7, 3'd0);
    run_prog("halt5");

    // branch 2 -> 254, wrap 255 -> 0, second BNO falls through to HALT
    clear_prog();
    imem[2]   = enc(3'b111, 3'd0, 3'd2);
    imem[3]   = enc(3'b110, 3'd7, 3'd0);
    imem[255] = enc(3'b010, 3'd1, 3'd2);
    init_rf[1] = 8'd200; init_rf[2] = 8'd100;
    run_prog("wrap");

    // three ADDs + HALT
    clear_prog();
    for (int a = 0; a < 3; a++) imem[a] = enc(3'b010, 3'd1, 3'd2);
    imem[3] = enc(3'b110, 3'd7, 3'd0);
    init_rf[1] = 8'd3; init_rf[2] = 8'd4;
    run_prog("add3");

    // reset during EXEC of the second ADD aborts it
    clear_prog();
    imem[0] = enc(3'b010, 3'd1, 3'd2);
    imem[1] = enc(3'b010, 3'd1, 3'd2);
    imem[2] = enc(3'b110, 3'd7, 3'd0);
    init_rf[1] = 8'd200; init_rf[2] = 8'd100;
    apply_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("rstx.opc", 32'(bus.alu_opcode), 32'h10);
    chk("rstx.flag_pre", 32'(flag), 32'd1);
    chk("rstx.addr_pre", 32'(bus.imem_addr), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstx.we", 32'(bus.rf_we), 32'd0);
    chk("rstx.flag", 32'(flag), 32'd0);
    chk("rstx.addr", 32'(bus.imem_addr), 32'd0);
    chk("rstx.opc_after", 32'(bus.alu_opcode), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstx.rf1", 32'(rf[1]), 32'd44);
    chk("rstx.idle_addr", 32'(bus.imem_addr), 32'd0);
    chk("rstx.idle_we", 32'(bus.rf_we), 32'd0);
    chk("rstx.done", 32'(done), 32'd0);

    // random programs that the model shows will halt
    for (int p = 0; p < 20; p++) begin
      do begin
        for (int a = 0; a < 256; a++) imem[a] = 9'($urandom_range(0, 511));
        for (int r = 0; r < 8; r++) init_rf[r] = 8'($urandom);
        model_run();
      end while (!m_halt);
      run_prog($sformatf("rnd%0d", p));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
